// File: rtl/cond_pkg.sv
// Shared types for conditional execution: ARM condition codes, NZCV flag struct, FlagW masks.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition evaluator; shared with the decode-stage branch predictor.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            EQ: cond_ex = flags.z;
            NE: cond_ex = ~flags.z;
            CS: cond_ex = flags.c;
            CC: cond_ex = ~flags.c;
            MI: cond_ex = flags.n;
            PL: cond_ex = ~flags.n;
            VS: cond_ex = flags.v;
            VC: cond_ex = ~flags.v;
            HI: cond_ex = flags.c & ~flags.z;
            LS: cond_ex = ~flags.c | flags.z;
            GE: cond_ex = (flags.n == flags.v);
            LT: cond_ex = (flags.n != flags.v);
            GT: cond_ex = ~flags.z & (flags.n == flags.v);
            LE: cond_ex = flags.z | (flags.n != flags.v);
            default: cond_ex = 1'b1;  // AL and the unused 1111 encoding
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Registered conditional-execution stage (Execute -> Memory) with per-context NZCV banks.
// Optional squash counter enabled by defining COND_SQUASH_CNT_EN.
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [CTX_W-1:0] i_ctx,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic [3:0]       ALUFlags,
    output logic             o_valid,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CTX_W-1:0] o_ctx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] squash_cnt
);

    flags_t           bank_q [NUM_CTX];
    flags_t           bank_d [NUM_CTX];
    logic             valid_q, valid_d;
    logic             pcsrc_q, pcsrc_d;
    logic             regwrite_q, regwrite_d;
    logic             memwrite_q, memwrite_d;
    logic [CTX_W-1:0] ctx_q, ctx_d;
    logic [CTX_W-1:0] ctx_eff;
    flags_t           cur_flags;
    logic             cond_ex;
    logic             accept;

    // Out-of-range context ids alias onto bank 0.
    assign ctx_eff   = (int'(i_ctx) < NUM_CTX) ? i_ctx : '0;
    assign cur_flags = bank_q[ctx_eff];
    assign accept    = i_valid & ~i_stall & ~i_flush;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (cur_flags),
        .cond_ex (cond_ex)
    );

    always_comb begin
        bank_d     = bank_q;
        valid_d    = valid_q;
        pcsrc_d    = pcsrc_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;
        ctx_d      = ctx_q;
        if (i_flush) begin
            valid_d    = 1'b0;
            pcsrc_d    = 1'b0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
        end else if (!i_stall) begin
            valid_d    = i_valid;
            pcsrc_d    = i_valid & PCS & cond_ex;
            regwrite_d = i_valid & RegW & ~NoWrite & cond_ex;
            memwrite_d = i_valid & MemW & cond_ex;
            if (i_valid) ctx_d = ctx_eff;
        end
        if (accept && cond_ex) begin
            if ((FlagW & FLAGW_NZ) != 2'b00) begin
                bank_d[ctx_eff].n = ALUFlags[3];
                bank_d[ctx_eff].z = ALUFlags[2];
            end
            if ((FlagW & FLAGW_CV) != 2'b00) begin
                bank_d[ctx_eff].c = ALUFlags[1];
                bank_d[ctx_eff].v = ALUFlags[0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CTX; i++) bank_q[i] <= '0;
            valid_q    <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            ctx_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) bank_q[i] <= bank_d[i];
            valid_q    <= valid_d;
            pcsrc_q    <= pcsrc_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            ctx_q      <= ctx_d;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Saturating count of accepted instructions whose condition failed.
    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (accept && !cond_ex && (squash_cnt_q != '1)) squash_cnt_d = squash_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) squash_cnt_q <= '0;
        else       squash_cnt_q <= squash_cnt_d;
    end

    assign squash_cnt = squash_cnt_q;
`else
    assign squash_cnt = '0;
`endif

    assign o_valid  = valid_q;
    assign PCSrc    = pcsrc_q;
    assign RegWrite = regwrite_q;
    assign MemWrite = memwrite_q;
    assign o_ctx    = ctx_q;
    assign Flags    = cur_flags;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed vector table, hand sequences and random stimulus vs a reference model.
module tb_cond_exec_stage;

    localparam int NUM_CTX = 2;
    localparam int CTX_W   = 1;
    localparam int CNT_W   = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             i_valid, i_stall, i_flush;
    logic [CTX_W-1:0] i_ctx;
    logic [3:0]       Cond;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic [3:0]       ALUFlags;
    logic             o_valid, PCSrc, RegWrite, MemWrite;
    logic [CTX_W-1:0] o_ctx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] squash_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [3:0] m_bank [NUM_CTX];
    logic       m_valid, m_pcs, m_rw, m_mw;
    logic [CTX_W-1:0] m_ctx;
    int         m_cnt;

    always #5 CLK = ~CLK;

    cond_exec_stage #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .i_ctx(i_ctx), .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .ALUFlags(ALUFlags), .o_valid(o_valid), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .o_ctx(o_ctx), .Flags(Flags),
        .squash_cnt(squash_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM evaluates cond[3:1] as a base test and cond[0] inverts it; 111x always executes.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic set_in(input logic v, s, f, input logic [CTX_W-1:0] c, input logic [3:0] cd,
                          input logic [1:0] fw, input logic pcs_i, rw_i, mw_i, nw_i,
                          input logic [3:0] alu);
        i_valid = v; i_stall = s; i_flush = f; i_ctx = c; Cond = cd; FlagW = fw;
        PCS = pcs_i; RegW = rw_i; MemW = mw_i; NoWrite = nw_i; ALUFlags = alu;
    endtask

    // Check combinational Flags, advance one clock, step the model, then check registered outputs.
    task automatic cycle();
        int  cidx;
        bit  ce;
        #1;
        cidx = (int'(i_ctx) < NUM_CTX) ? int'(i_ctx) : 0;
        if (!RESET) chk("flags_comb", {28'd0, Flags}, {28'd0, m_bank[cidx]});
        ce = cond_holds(Cond, m_bank[cidx]);
        if (RESET) begin
            for (int i = 0; i < NUM_CTX; i++) m_bank[i] = 4'b0000;
            m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_ctx = '0; m_cnt = 0;
        end else if (i_flush) begin
            m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0;
        end else if (!i_stall) begin
            m_valid = i_valid;
            m_pcs   = i_valid && PCS && ce;
            m_rw    = i_valid && RegW && !NoWrite && ce;
            m_mw    = i_valid && MemW && ce;
            if (i_valid) m_ctx = CTX_W'(cidx);
            if (i_valid && ce) begin
                if (FlagW[1]) m_bank[cidx][3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_bank[cidx][1:0] = ALUFlags[1:0];
            end
`ifdef COND_SQUASH_CNT_EN
            if (i_valid && !ce && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        end
        @(posedge CLK);
        #1;
        chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
        chk("PCSrc", {31'd0, PCSrc}, {31'd0, m_pcs});
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
        chk("MemWrite", {31'd0, MemWrite}, {31'd0, m_mw});
        if (m_valid) chk("o_ctx", 32'(o_ctx), 32'(m_ctx));
        chk("squash_cnt", 32'(squash_cnt), 32'(m_cnt));
    endtask

    typedef struct {
        logic v, s, f;
        logic [CTX_W-1:0] c;
        logic [3:0] cond;
        logic [1:0] fw;
        logic pcs, rw, mw, nw;
        logic [3:0] alu;
        logic ev, epc, erw, emw;
        logic [3:0] ef;
    } vec_t;

    vec_t vecs [14];

    initial begin
        for (int i = 0; i < NUM_CTX; i++) m_bank[i] = 4'b0000;
        m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_ctx = '0; m_cnt = 0;

        //           v  s  f  c  cond     fw     pcs rw mw nw alu       ev epc erw emw ef
        vecs[0]  = '{1, 0, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 1, 4'b0100, 1, 0, 0, 0, 4'b0100};
        vecs[1]  = '{1, 0, 0, 0, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b0100};
        vecs[2]  = '{1, 0, 0, 1, 4'b1110, 2'b10, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 4'b0100};
        vecs[3]  = '{1, 0, 0, 0, 4'b1110, 2'b11, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000};
        vecs[4]  = '{1, 0, 0, 0, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000};
        vecs[5]  = '{1, 0, 0, 1, 4'b1110, 2'b11, 0, 0, 0, 1, 4'b1111, 1, 0, 0, 0, 4'b1111};
        vecs[6]  = '{1, 0, 0, 1, 4'b1110, 2'b01, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b1100};
        vecs[7]  = '{1, 0, 0, 0, 4'b1110, 2'b00, 0, 0, 1, 0, 4'b0000, 1, 0, 0, 1, 4'b0000};
        vecs[8]  = '{1, 1, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b1111, 1, 0, 0, 1, 4'b0000};
        vecs[9]  = '{1, 1, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b1111, 1, 0, 0, 1, 4'b0000};
        vecs[10] = '{1, 1, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b1111, 1, 0, 0, 1, 4'b0000};
        vecs[11] = '{1, 1, 1, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000};
        vecs[12] = '{0, 0, 0, 0, 4'b1110, 2'b11, 0, 1, 1, 0, 4'b1111, 0, 0, 0, 0, 4'b0000};
        vecs[13] = '{1, 0, 0, 1, 4'b1100, 2'b11, 1, 1, 1, 0, 4'b0000, 1, 0, 0, 0, 4'b1100};

        // reset
        RESET = 1'b1;
        set_in(0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000);
        @(posedge CLK);
        cycle();
        RESET = 1'b0;
        chk("reset_flags0", {28'd0, Flags}, 32'd0);
        chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_squash", 32'(squash_cnt), 32'd0);

        // directed table
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].c, vecs[i].cond, vecs[i].fw,
                   vecs[i].pcs, vecs[i].rw, vecs[i].mw, vecs[i].nw, vecs[i].alu);
            cycle();
            chk($sformatf("vec%0d_o_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_PCSrc", i), {31'd0, PCSrc}, {31'd0, vecs[i].epc});
            chk($sformatf("vec%0d_RegWrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].erw});
            chk($sformatf("vec%0d_MemWrite", i), {31'd0, MemWrite}, {31'd0, vecs[i].emw});
            chk($sformatf("vec%0d_Flags", i), {28'd0, Flags}, {28'd0, vecs[i].ef});
        end
`ifdef COND_SQUASH_CNT_EN
        chk("squash_after_table", 32'(squash_cnt), 32'd2);
`else
        chk("squash_after_table", 32'(squash_cnt), 32'd0);
`endif

        // saturation: ctx0 flags are 0000, EQ fails every time
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 0, 0, 4'b0000, 2'b11, 1, 1, 1, 0, 4'b1111);
            cycle();
        end
`ifdef COND_SQUASH_CNT_EN
        chk("squash_saturated", 32'(squash_cnt), 32'hF);
`else
        chk("squash_saturated", 32'(squash_cnt), 32'd0);
`endif
        chk("sat_flags_unchanged", {28'd0, Flags}, 32'd0);

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            RESET = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, CTX_W'($urandom_range(0, NUM_CTX - 1)),
                   4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            cycle();
        end
        RESET = 1'b0;

        // load both banks, then reset during stall+flush clears everything
        set_in(1, 0, 0, 0, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b1010);
        cycle();
        set_in(1, 0, 0, 1, 4'b1110, 2'b11, 0, 1, 0, 0, 4'b0110);
        cycle();
        RESET = 1'b1;
        set_in(1, 1, 1, 0, 4'b1110, 2'b11, 0, 1, 1, 0, 4'b1111);
        cycle();
        RESET = 1'b0;
        set_in(0, 1, 0, 0, 4'b1110, 2'b00, 0, 0, 0, 0, 4'b0000);
        #1;
        chk("rst_stall_flags0", {28'd0, Flags}, 32'd0);
        i_ctx = 1'b1;
        #1;
        chk("rst_stall_flags1", {28'd0, Flags}, 32'd0);
        chk("rst_stall_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_stall_squash", 32'(squash_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
